// File: rtl/ramb_pkg.sv
// Shared types and elaboration helpers for the asymmetric dual-port RAM.
package ramb_pkg;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE
  } wmode_e;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  // Ceiling log2, valid for value >= 1; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Unknown strings fall back to write-first, the most common primitive default.
  function automatic wmode_e str2wmode(input string s);
    if (s == "READ_FIRST") return WM_READ_FIRST;
    if (s == "NO_CHANGE")  return WM_NO_CHANGE;
    return WM_WRITE_FIRST;
  endfunction

endpackage

// File: rtl/ramb_clear_seq.sv
// Reset-time clear sequencer: walks every wide word once, writing zero.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_CLEAR | clearing word cnt this cycle; ports locked out (busy=1)
//  ST_RUN   | normal operation, sequencer idle
module ramb_clear_seq
  import ramb_pkg::*;
#(
  parameter int DEPTH_B        = 256,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int AW             = clog2(DEPTH_B)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_e        state;
  logic [AW-1:0] cnt;

  // State and word counter; a reset mid-clear restarts from word 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == AW'(DEPTH_B - 1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // The clear write is held off while reset is asserted so reset alone never alters the array.
  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy & rstn;
  assign clr_addr = cnt;

endmodule

// File: rtl/ramb_asym_dp.sv
// Single-clock true dual-port RAM: narrow port A, wide port B, shared wide-word array.
module ramb_asym_dp
  import ramb_pkg::*;
#(
  parameter int    WIDTH_A         = 4,
  parameter int    WIDTH_B         = 16,
  parameter int    DEPTH_B         = 256,
  parameter string WRITE_MODE_A    = "WRITE_FIRST",
  parameter string WRITE_MODE_B    = "WRITE_FIRST",
  parameter bit    DO_REG          = 1'b0,
  parameter bit    CLEAR_ON_RESET  = 1'b1,
  parameter string COLLISION_CHECK = "ALL",
  localparam int   RATIO           = WIDTH_B / WIDTH_A,
  localparam int   LR              = clog2(RATIO),
  localparam int   BAW             = clog2(DEPTH_B),
  localparam int   AAW             = BAW + LR
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ena,
  input  logic               wea,
  input  logic               rsta,
  input  logic [AAW-1:0]     addra,
  input  logic [WIDTH_A-1:0] dia,
  output logic [WIDTH_A-1:0] doa,
  input  logic               enb,
  input  logic               web,
  input  logic               rstb,
  input  logic [BAW-1:0]     addrb,
  input  logic [WIDTH_B-1:0] dib,
  output logic [WIDTH_B-1:0] dob,
  output logic               busy,
  output logic               coll
);

  localparam wmode_e WMA     = str2wmode(WRITE_MODE_A);
  localparam wmode_e WMB     = str2wmode(WRITE_MODE_B);
  localparam bit     COLL_EN = (COLLISION_CHECK != "NONE");
  localparam int     LW      = (LR > 0) ? LR : 1;

  logic [WIDTH_B-1:0] mem [0:DEPTH_B-1];

  logic               busy_i;
  logic               clr_we;
  logic [BAW-1:0]     clr_addr;

  logic [BAW-1:0]     a_word;
  logic [LW-1:0]      a_lane;
  logic [WIDTH_B-1:0] a_mask;
  logic [WIDTH_B-1:0] a_wdata;
  logic [WIDTH_B-1:0] a_rd_word;
  logic [WIDTH_A-1:0] a_old;
  logic [WIDTH_B-1:0] b_old;

  logic               run;
  logic               a_en, b_en, a_we, b_we, a_we_eff;
  logic               same_word, coll_now;

  logic [WIDTH_A-1:0] a_lat, a_lat_d, a_pipe;
  logic [WIDTH_B-1:0] b_lat, b_lat_d, b_pipe;

  ramb_clear_seq #(
    .DEPTH_B        (DEPTH_B),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (BAW)
  ) u_clear (
    .clk      (clk),
    .rstn     (rstn),
    .busy     (busy_i),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign a_word = addra[AAW-1:LR];

  if (LR > 0) begin : g_lane
    assign a_lane = addra[LR-1:0];
  end else begin : g_nolane
    assign a_lane = '0;
  end

  // Lane select for port A: mask, replicated write data and the old lane value.
  always_comb begin
    a_mask    = WIDTH_B'({WIDTH_A{1'b1}}) << (int'(a_lane) * WIDTH_A);
    a_wdata   = {RATIO{dia}};
    a_rd_word = mem[a_word];
    a_old     = WIDTH_A'(a_rd_word >> (int'(a_lane) * WIDTH_A));
    b_old     = mem[addrb];
  end

  // Port qualification; port B wins a write-write collision on the shared word.
  assign run       = rstn & ~busy_i;
  assign a_en      = ena & run;
  assign b_en      = enb & run;
  assign a_we      = a_en & wea;
  assign b_we      = b_en & web;
  assign same_word = (a_word == addrb);
  assign a_we_eff  = a_we & ~(b_we & same_word);
  assign coll_now  = COLL_EN & a_en & b_en & same_word & (a_we | b_we);

  // Array writes; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (b_we)     mem[addrb]  <= dib;
      if (a_we_eff) mem[a_word] <= (a_rd_word & ~a_mask) | (a_wdata & a_mask);
    end
  end

  // Port A output latch next value per write mode.
  always_comb begin
    a_lat_d = a_lat;
    if (a_en) begin
      if (rsta) begin
        a_lat_d = '0;
      end else if (wea) begin
        case (WMA)
          WM_WRITE_FIRST: a_lat_d = dia;
          WM_READ_FIRST:  a_lat_d = a_old;
          default:        a_lat_d = a_lat;
        endcase
      end else begin
        a_lat_d = a_old;
      end
    end
  end

  // Port B output latch next value per write mode.
  always_comb begin
    b_lat_d = b_lat;
    if (b_en) begin
      if (rstb) begin
        b_lat_d = '0;
      end else if (web) begin
        case (WMB)
          WM_WRITE_FIRST: b_lat_d = dib;
          WM_READ_FIRST:  b_lat_d = b_old;
          default:        b_lat_d = b_lat;
        endcase
      end else begin
        b_lat_d = b_old;
      end
    end
  end

  // Output latches, free-running pipe stage and the collision pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_lat  <= '0;
      b_lat  <= '0;
      a_pipe <= '0;
      b_pipe <= '0;
      coll   <= 1'b0;
    end else begin
      a_lat  <= a_lat_d;
      b_lat  <= b_lat_d;
      a_pipe <= a_lat;
      b_pipe <= b_lat;
      coll   <= coll_now;
    end
  end

  assign doa  = DO_REG ? a_pipe : a_lat;
  assign dob  = DO_REG ? b_pipe : b_lat;
  assign busy = busy_i;

endmodule
